// File: rtl/interfaccia_lettura_carattere.sv
// rtl/interfaccia_lettura_carattere.sv - keyboard read port: character FIFO with RBR/RSR registers
module interfaccia_lettura_carattere #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       s_,
  input  logic       ior_,
  input  logic       a0,
  output logic [7:0] d7_d0,
  output logic       d_oe,
  input  logic       kbd_strobe,
  input  logic [7:0] kbd_data,
  output logic       irq
);

  logic [7:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             rd_act_q;
  logic             a0_q, a0_d;

  logic       rd_act;
  logic       end_rd;
  logic       not_empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic       ovr_clr;
  logic [7:0] rsr;

  always_comb begin
    rd_act    = ~s_ & ~ior_;
    end_rd    = rd_act_q & ~rd_act;
    not_empty = (count_q != '0);
    full      = (count_q == (PTR_W+1)'(DEPTH));
    rsr       = {5'b00000, full, ovr_q, not_empty};

    // Side effects belong to the completed read, so they use the a0 captured while it was active.
    pop     = end_rd & ~a0_q & not_empty;
    ovr_clr = end_rd & a0_q;
    push    = kbd_strobe & (~full | pop);
    drop    = kbd_strobe & full & ~pop;

    a0_d     = rd_act ? a0 : a0_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push)
      count_d = count_q - (PTR_W+1)'(1);
    ovr_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

    d_oe  = rd_act;
    d7_d0 = 8'h00;
    if (rd_act) begin
      if (a0)
        d7_d0 = rsr;
      else if (not_empty)
        d7_d0 = fifo_q[rd_ptr_q];
    end

    irq = not_empty;
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      rd_act_q <= 1'b0;
      a0_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      rd_act_q <= rd_act;
      a0_q     <= a0_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_ && push)
      fifo_q[wr_ptr_q] <= kbd_data;
  end

endmodule

// File: tb/tb_interfaccia_lettura_carattere.sv
// tb/tb_interfaccia_lettura_carattere.sv - randomized self-checking bench against a queue model
module tb_interfaccia_lettura_carattere;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_;
  logic       s_;
  logic       ior_;
  logic       a0;
  logic       kbd_strobe;
  logic [7:0] kbd_data;
  logic [7:0] d7_d0;
  logic       d_oe;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         movr;

  interfaccia_lettura_carattere #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock(clock), .reset_(reset_), .s_(s_), .ior_(ior_), .a0(a0),
    .d7_d0(d7_d0), .d_oe(d_oe), .kbd_strobe(kbd_strobe), .kbd_data(kbd_data), .irq(irq)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_read(input logic sel);
    logic [7:0] r;
    if (sel) begin
      r = {5'b00000, mq.size() == DEPTH, movr, mq.size() != 0};
      movr = 1'b0;
    end else if (mq.size() != 0) begin
      r = mq.pop_front();
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  function automatic void model_push(input logic [7:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else movr = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    kbd_strobe = 1'b1;
    kbd_data   = d;
    tick();
    kbd_strobe = 1'b0;
  endtask

  task automatic do_read(input logic sel, input int len, input bit strobe_end,
                         input logic [7:0] sd, output logic [7:0] val, output logic oe);
    s_   = 1'b0;
    ior_ = 1'b0;
    a0   = sel;
    #1;
    val = d7_d0;
    oe  = d_oe;
    repeat (len) tick();
    s_   = 1'b1;
    ior_ = 1'b1;
    if (strobe_end) begin
      kbd_strobe = 1'b1;
      kbd_data   = sd;
    end
    tick();
    kbd_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v, e;
    logic oe;
    s_ = 1'b1; ior_ = 1'b1; a0 = 1'b0; kbd_strobe = 1'b0; kbd_data = 8'h00;
    reset_ = 1'b1;
    repeat (2) begin
      kbd_strobe = 1'b1;
      kbd_data   = 8'($urandom);
      tick();
    end
    reset_ = 1'b0;
    kbd_strobe = 1'b0;
    mq.delete();
    movr = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL reset_doe: got %b expected 0", d_oe); end
    checks++; if (d7_d0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", d7_d0); end
    e = model_read(1'b1);
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe);
    checks++; if (v !== e || e !== 8'h00) begin errors++; $display("FAIL reset_rsr: got %h expected 00", v); end
    e = model_read(1'b0);
    do_read(1'b0, 1, 1'b0, 8'h00, v, oe);
    checks++; if (v !== e) begin errors++; $display("FAIL reset_rbr: got %h expected %h", v, e); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    logic oe;
    push(8'h41); model_push(8'h41);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", irq); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); void'(model_read(1'b1));
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL single_rsr: got %h expected 01", v); end
    do_read(1'b0, 3, 1'b0, 8'h00, v, oe); void'(model_read(1'b0));
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL single_rbr: got %h expected 41", v); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL single_doe: got %b expected 1", oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_after: got %b expected 0", irq); end
    checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL single_doe_after: got %b expected 0", d_oe); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); void'(model_read(1'b1));
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL single_rsr_after: got %h expected 00", v); end
  endtask

  task automatic test_order_wrap();
    logic [7:0] v, e;
    logic oe;
    logic [7:0] chars[4];
    chars = '{8'h61, 8'h62, 8'h63, 8'h64};
    foreach (chars[i]) begin push(chars[i]); model_push(chars[i]); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); e = model_read(1'b1);
    checks++; if (v !== e || v !== 8'h05) begin errors++; $display("FAIL order_rsr: got %h expected 05", v); end
    for (int i = 0; i < 2; i++) begin
      e = model_read(1'b0);
      do_read(1'b0, 2, 1'b0, 8'h00, v, oe);
      checks++; if (v !== e) begin errors++; $display("FAIL order_rbr%0d: got %h expected %h", i, v, e); end
    end
    push(8'h65); model_push(8'h65);
    push(8'h66); model_push(8'h66);
    for (int i = 0; i < 4; i++) begin
      e = model_read(1'b0);
      do_read(1'b0, 1, 1'b0, 8'h00, v, oe);
      checks++; if (v !== e) begin errors++; $display("FAIL wrap_rbr%0d: got %h expected %h", i, v, e); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] v, e;
    logic oe;
    for (int i = 0; i < 5; i++) begin push(8'(8'h31 + i)); model_push(8'(8'h31 + i)); end
    do_read(1'b1, 2, 1'b0, 8'h00, v, oe); e = model_read(1'b1);
    checks++; if (v !== e || v !== 8'h07) begin errors++; $display("FAIL ovr_rsr: got %h expected 07", v); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); e = model_read(1'b1);
    checks++; if (v !== e || v !== 8'h05) begin errors++; $display("FAIL ovr_rsr_clr: got %h expected 05", v); end
    for (int i = 0; i < 5; i++) begin
      e = model_read(1'b0);
      do_read(1'b0, 1, 1'b0, 8'h00, v, oe);
      checks++; if (v !== e) begin errors++; $display("FAIL ovr_rbr%0d: got %h expected %h", i, v, e); end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] v, e;
    logic oe;
    for (int i = 0; i < 4; i++) begin push(8'(8'h31 + i)); model_push(8'(8'h31 + i)); end
    e = model_read(1'b0); model_push(8'h36);
    do_read(1'b0, 1, 1'b1, 8'h36, v, oe);
    checks++; if (v !== e || v !== 8'h31) begin errors++; $display("FAIL full_pop_rbr: got %h expected 31", v); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); e = model_read(1'b1);
    checks++; if (v !== e || v !== 8'h05) begin errors++; $display("FAIL full_pop_rsr: got %h expected 05", v); end
    for (int i = 0; i < 4; i++) begin
      e = model_read(1'b0);
      do_read(1'b0, 1, 1'b0, 8'h00, v, oe);
      checks++; if (v !== e) begin errors++; $display("FAIL full_pop_rbr%0d: got %h expected %h", i, v, e); end
    end
    do_read(1'b0, 1, 1'b0, 8'h00, v, oe); e = model_read(1'b0);
    checks++; if (v !== 8'h00 || e !== 8'h00) begin errors++; $display("FAIL empty_rbr: got %h expected 00", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL empty_irq: got %b expected 0", irq); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] v;
    logic oe;
    push(8'h51); push(8'h52);
    s_ = 1'b0; ior_ = 1'b0; a0 = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();
    reset_ = 1'b0;
    tick();
    s_ = 1'b1; ior_ = 1'b1;
    tick();
    mq.delete(); movr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    do_read(1'b1, 1, 1'b0, 8'h00, v, oe); void'(model_read(1'b1));
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL midrst_rsr: got %h expected 00", v); end
    push(8'h77); model_push(8'h77);
    do_read(1'b0, 1, 1'b0, 8'h00, v, oe); void'(model_read(1'b0));
    checks++; if (v !== 8'h77) begin errors++; $display("FAIL midrst_rbr: got %h expected 77", v); end
  endtask

  task automatic test_random();
    logic [7:0] v, e, d;
    logic oe;
    int op;
    bit se;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      if (op < 5) begin
        push(d); model_push(d);
      end else begin
        se = ($urandom_range(0, 2) == 0);
        e = model_read(op >= 8);
        if (se) model_push(d);
        do_read(op >= 8, $urandom_range(1, 3), se, d, v, oe);
        checks++; if (v !== e) begin errors++; $display("FAIL rand_read%0d: got %h expected %h", n, v, e); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rand_doe%0d: got %b expected 1", n, oe); end
      end
      checks++; if (irq !== (mq.size() != 0)) begin errors++; $display("FAIL rand_irq%0d: got %b expected %b", n, irq, mq.size() != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order_wrap();
    test_overrun();
    test_full_pop();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
